// File: rtl/neuron_ram_pkg.sv
// Shared definitions for the neuron RAM sweep controller: neuron word geometry,
// field offsets inside a neuron word, and the controller state encoding.
package neuron_ram_pkg;

    localparam int DATA_WIDTH           = 48;  // 16 integer + 32 fractional bits
    localparam int TREF_WIDTH           = 8;   // refractory counter
    localparam int NEURON_WIDTH_LOGICAL = 11;  // neuron ID
    localparam int ADDR_WIDTH           = 5;   // neuron RAM address
    localparam int NUM_WORDS            = 2 ** ADDR_WIDTH;

    // Six fixed-point fields, refractory field, three flags, neuron ID, two spare bits.
    function automatic int calc_word_width(input int data_w, input int tref_w, input int id_w);
        return data_w * 6 + tref_w + 3 + id_w + 2;
    endfunction

    localparam int WORD_WIDTH = calc_word_width(DATA_WIDTH, TREF_WIDTH, NEURON_WIDTH_LOGICAL);

    // Field layout, LSB first.
    localparam int OFS_DATA0     = 0;
    localparam int OFS_TREF      = 6 * DATA_WIDTH;
    localparam int OFS_FLAGS     = OFS_TREF + TREF_WIDTH;
    localparam int OFS_NEURON_ID = OFS_FLAGS + 3;
    localparam int OFS_SPARE     = OFS_NEURON_ID + NEURON_WIDTH_LOGICAL;

    // LSB of fixed-point field k (0..5).
    function automatic int data_field_lsb(input int k);
        return OFS_DATA0 + k * DATA_WIDTH;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_OFFER  = 3'd2,
        S_RESULT = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_HACC   = 3'd6,
        S_HRSP   = 3'd7
    } sweep_state_e;

endpackage

// File: rtl/neuron_ram_sweep_controller.sv
// Sequences the single-port neuron RAM: on Start it walks neurons 0..count-1 through
// read -> offer to update unit -> accept result -> write back; when idle it serves
// single host reads/writes. All RAM controls are decoded from the state register only.
module neuron_ram_sweep_controller
    import neuron_ram_pkg::*;
(
    input  logic                  Clock_i,
    input  logic                  Reset_i,
    input  logic                  Start_i,
    input  logic [ADDR_WIDTH:0]   NeuronCount_i,
    output logic                  Busy_o,
    output logic                  Done_o,
    input  logic                  HostReq_i,
    input  logic                  HostWrite_i,
    input  logic [ADDR_WIDTH-1:0] HostAddress_i,
    input  logic [WORD_WIDTH-1:0] HostData_i,
    output logic                  HostAck_o,
    output logic [WORD_WIDTH-1:0] HostReadData_o,
    output logic                  UpdValid_o,
    input  logic                  UpdReady_i,
    output logic [ADDR_WIDTH-1:0] UpdAddress_o,
    output logic [WORD_WIDTH-1:0] UpdData_o,
    input  logic                  ResValid_i,
    output logic                  ResReady_o,
    input  logic [WORD_WIDTH-1:0] ResData_i,
    output logic                  RamChipEnable_o,
    output logic                  RamWriteEnable_o,
    output logic [ADDR_WIDTH-1:0] RamAddress_o,
    output logic [WORD_WIDTH-1:0] RamWriteData_o,
    input  logic [WORD_WIDTH-1:0] RamReadData_i
);

    localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    sweep_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [WORD_WIDTH-1:0] wb_q, wb_d;
    logic                  host_write_q, host_write_d;
    logic                  last_idx;

    // The sweep ends on the count compare; the index itself never wraps.
    assign last_idx = ({1'b0, idx_q} == (count_q - (ADDR_WIDTH + 1)'(1)));

    // State, index, latched count, writeback word and host direction registers.
    always_ff @(posedge Clock_i) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (Reset_i) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            count_q      <= '0;
            wb_q         <= '0;
            host_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            wb_q         <= wb_d;
            host_write_q <= host_write_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d          = state_q;
        idx_d            = idx_q;
        count_d          = count_q;
        wb_d             = wb_q;
        host_write_d     = host_write_q;
        Busy_o           = (state_q != S_IDLE);
        Done_o           = 1'b0;
        HostAck_o        = 1'b0;
        HostReadData_o   = '0;
        UpdValid_o       = 1'b0;
        UpdAddress_o     = '0;
        UpdData_o        = '0;
        ResReady_o       = 1'b0;
        RamChipEnable_o  = 1'b0;
        RamWriteEnable_o = 1'b0;
        RamAddress_o     = '0;
        RamWriteData_o   = '0;

        case (state_q)
            S_IDLE: begin
                // Start wins over a simultaneous host request; the host simply stays pending.
                if (Start_i) begin
                    count_d = (NeuronCount_i > MAX_COUNT) ? MAX_COUNT : NeuronCount_i;
                    idx_d   = '0;
                    state_d = (NeuronCount_i == '0) ? S_DONE : S_READ;
                end else if (HostReq_i) begin
                    host_write_d = HostWrite_i;
                    state_d      = S_HACC;
                end
            end
            S_READ: begin
                RamChipEnable_o = 1'b1;
                RamAddress_o    = idx_q;
                state_d         = S_OFFER;
            end
            S_OFFER: begin
                // RAM is disabled here, so its output word is held while the update unit stalls.
                UpdValid_o   = 1'b1;
                UpdAddress_o = idx_q;
                UpdData_o    = RamReadData_i;
                if (UpdReady_i) begin
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                ResReady_o = 1'b1;
                if (ResValid_i) begin
                    wb_d    = ResData_i;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                RamChipEnable_o  = 1'b1;
                RamWriteEnable_o = 1'b1;
                RamAddress_o     = idx_q;
                RamWriteData_o   = wb_q;
                if (last_idx) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + ADDR_WIDTH'(1);
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                Done_o  = 1'b1;
                idx_d   = '0;
                state_d = S_IDLE;
            end
            S_HACC: begin
                RamChipEnable_o  = 1'b1;
                RamWriteEnable_o = host_write_q;
                RamAddress_o     = HostAddress_i;
                RamWriteData_o   = host_write_q ? HostData_i : '0;
                state_d          = S_HRSP;
            end
            S_HRSP: begin
                HostAck_o      = 1'b1;
                HostReadData_o = host_write_q ? '0 : RamReadData_i;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_neuron_ram_sweep_controller.sv
// Self-checking bench for neuron_ram_sweep_controller: behavioural RAM, an update unit
// that returns word+delta with random stalls, and a word-array model of expected contents.
module tb_neuron_ram_sweep_controller;
    import neuron_ram_pkg::*;

    localparam int AW = ADDR_WIDTH;
    localparam int WW = WORD_WIDTH;
    localparam int NW = NUM_WORDS;

    typedef logic [WW-1:0] word_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW:0]   neuron_count;
    logic          busy, done;
    logic          host_req, host_write;
    logic [AW-1:0] host_addr;
    word_t         host_data;
    logic          host_ack;
    word_t         host_rdata;
    logic          upd_valid, upd_ready;
    logic [AW-1:0] upd_addr;
    word_t         upd_data;
    logic          res_valid, res_ready;
    word_t         res_data;
    logic          ram_ce, ram_we;
    logic [AW-1:0] ram_addr;
    word_t         ram_wdata, ram_rdata;

    int checks = 0;
    int errors = 0;
    word_t exp_mem [NW];

    neuron_ram_sweep_controller dut (
        .Clock_i          (clk),
        .Reset_i          (reset),
        .Start_i          (start),
        .NeuronCount_i    (neuron_count),
        .Busy_o           (busy),
        .Done_o           (done),
        .HostReq_i        (host_req),
        .HostWrite_i      (host_write),
        .HostAddress_i    (host_addr),
        .HostData_i       (host_data),
        .HostAck_o        (host_ack),
        .HostReadData_o   (host_rdata),
        .UpdValid_o       (upd_valid),
        .UpdReady_i       (upd_ready),
        .UpdAddress_o     (upd_addr),
        .UpdData_o        (upd_data),
        .ResValid_i       (res_valid),
        .ResReady_o       (res_ready),
        .ResData_i        (res_data),
        .RamChipEnable_o  (ram_ce),
        .RamWriteEnable_o (ram_we),
        .RamAddress_o     (ram_addr),
        .RamWriteData_o   (ram_wdata),
        .RamReadData_i    (ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port RAM: registered read address, synchronous write, both gated by CE.
    word_t         ram_mem [NW];
    logic [AW-1:0] ram_areg;
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            ram_areg <= ram_addr;
        end
    end
    assign ram_rdata = ram_mem[ram_areg];

    task automatic check(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic word_t rand_word();
        word_t w;
        w = '0;
        for (int i = 0; i < 10; i++) w = {w[WW-33:0], 32'($urandom)};
        return w;
    endfunction

    function automatic logic any_output();
        return |{busy, done, host_ack, host_rdata, upd_valid, upd_addr, upd_data,
                 res_ready, ram_ce, ram_we, ram_addr, ram_wdata};
    endfunction

    // One host access; ack is expected two cycles after the request is raised.
    task automatic host_access(input bit wr, input logic [AW-1:0] a, input word_t d, output word_t rd);
        int w;
        @(negedge clk);
        host_req = 1'b1; host_write = wr; host_addr = a; host_data = d;
        w = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (host_ack) begin w = i; break; end
        end
        check("host_ack_latency", w, 2);
        rd = host_rdata;
        if (wr) check("host_write_rdata_zero", host_rdata, 0);
        host_req = 1'b0; host_write = 1'b0; host_data = '0;
        @(negedge clk);
        check("host_ack_one_cycle", {host_ack, busy}, 0);
    endtask

    // One sweep request with the update unit returning word+delta after random stalls.
    task automatic run_sweep(input int n, input int ostall_min, input int ostall_max,
                             input int rstall_max, input word_t delta, input bit start_hold,
                             input bit with_host, input int abort_idx);
        int neff, done_k, offers, stalls, stall_left, rstall, w;
        bit in_offer, aborted, busy_ok, quiet_ok, ce_ok, stable_ok, data_ok, write_ok, ram_touched;
        word_t held;
        logic [AW-1:0] haddr;
        neff = (n > NW) ? NW : n;
        done_k = 0; offers = 0; stalls = 0; stall_left = 0; rstall = 0;
        in_offer = 0; aborted = 0; ram_touched = 0;
        busy_ok = 1; quiet_ok = 1; ce_ok = 1; stable_ok = 1; data_ok = 1; write_ok = 1;
        held = '0;
        haddr = AW'($urandom_range(NW - 1, 0));
        @(negedge clk);
        start = 1'b1;
        neuron_count = (AW + 1)'(n);
        if (with_host) begin host_req = 1'b1; host_write = 1'b0; host_addr = haddr; end
        for (int k = 1; k <= 4000; k++) begin
            @(negedge clk);
            if (!start_hold) start = 1'b0;
            if (!busy) busy_ok = 0;
            if (host_ack) quiet_ok = 0;
            if (ram_ce && (upd_valid || res_ready || done)) ce_ok = 0;
            if (ram_ce) ram_touched = 1;
            if (ram_ce && ram_we) begin
                if (offers == 0) write_ok = 0;
                else if (ram_addr !== AW'(offers - 1) || ram_wdata !== exp_mem[offers - 1] + delta) write_ok = 0;
            end
            if (upd_valid) begin
                if (!in_offer) begin
                    in_offer = 1;
                    held = upd_data;
                    stall_left = $urandom_range(ostall_max, ostall_min);
                    if (offers >= NW) data_ok = 0;
                    else if (upd_addr !== AW'(offers) || upd_data !== exp_mem[offers]) data_ok = 0;
                end else if (upd_data !== held || upd_addr !== AW'(offers)) begin
                    stable_ok = 0;
                end
                if (stall_left > 0) begin
                    upd_ready = 1'b0; stall_left--; stalls++;
                end else begin
                    upd_ready = 1'b1; res_data = held + delta; in_offer = 0; offers++;
                    rstall = $urandom_range(rstall_max, 0);
                end
            end else begin
                upd_ready = 1'b0;
            end
            if (res_ready) begin
                if (offers - 1 == abort_idx) begin
                    reset = 1'b1; res_valid = 1'b0; upd_ready = 1'b0; aborted = 1;
                    break;
                end
                if (rstall > 0) begin
                    res_valid = 1'b0; rstall--; stalls++;
                end else begin
                    res_valid = 1'b1;
                end
            end else begin
                res_valid = 1'b0;
            end
            if (done) begin done_k = k; break; end
        end
        start = 1'b0; upd_ready = 1'b0; res_valid = 1'b0;

        if (aborted) begin
            @(negedge clk);
            check("abort_outputs_zero", any_output(), 0);
            reset = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (done || busy) quiet_ok = 0;
            end
            check("abort_no_done", quiet_ok, 1);
            for (int i = 0; i < abort_idx; i++) exp_mem[i] += delta;
            return;
        end

        check("sweep_done_seen", done_k != 0, 1);
        check("sweep_cycles", done_k, 4 * neff + 1 + stalls);
        check("sweep_offers", offers, neff);
        check("sweep_busy_no_host", {busy_ok, quiet_ok}, 2'b11);
        check("sweep_ce_only_in_access", ce_ok, 1);
        check("sweep_offer_addr_data", data_ok, 1);
        check("sweep_offer_stable", stable_ok, 1);
        check("sweep_writeback", write_ok, 1);
        if (neff == 0) check("sweep_empty_no_ram", ram_touched, 0);
        for (int i = 0; i < neff; i++) exp_mem[i] += delta;

        if (with_host) begin
            w = 0;
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                if (host_ack) begin w = i; break; end
            end
            check("host_after_done_latency", w, 3);
            check("host_after_done_rdata", host_rdata, exp_mem[haddr]);
            host_req = 1'b0;
            @(negedge clk);
        end else begin
            @(negedge clk);
            check("idle_after_done", {busy, done}, 0);
        end
    endtask

    initial begin
        word_t rd, d;
        reset = 1'b1; start = 1'b0; neuron_count = '0;
        host_req = 1'b0; host_write = 1'b0; host_addr = '0; host_data = '0;
        upd_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", any_output(), 0);
        reset = 1'b0;

        // Load every word through the host port.
        for (int a = 0; a < NW; a++) begin
            d = rand_word();
            host_access(1'b1, AW'(a), d, rd);
            exp_mem[a] = d;
        end

        // Directed host write/read.
        host_access(1'b1, AW'(7), word_t'(12'hABC), rd);
        exp_mem[7] = word_t'(12'hABC);
        host_access(1'b0, AW'(7), '0, rd);
        check("host_read_addr7", rd, word_t'(12'hABC));

        // Three neurons, +1 update, no stalls: Done 13 cycles after Start.
        run_sweep(3, 0, 0, 0, word_t'(1), 1'b0, 1'b0, -1);
        // Update unit stalls five cycles on every offer.
        run_sweep(3, 5, 5, 2, rand_word(), 1'b0, 1'b0, -1);
        // Start and host request together: sweep first, host right after Done.
        run_sweep(1, 0, 0, 0, rand_word(), 1'b0, 1'b1, -1);
        // Empty sweep.
        run_sweep(0, 0, 0, 0, rand_word(), 1'b0, 1'b0, -1);
        // Oversized count clamps to the full RAM; Start held high must not re-trigger.
        run_sweep(40, 0, 2, 2, rand_word(), 1'b1, 1'b0, -1);
        // Random counts across the full NeuronCount range.
        for (int r = 0; r < 3; r++) begin
            run_sweep($urandom_range(63, 0), 0, 3, 3, rand_word(), 1'b0, 1'b0, -1);
        end
        // Reset while neuron 2 waits for its result, then a fresh sweep from index 0.
        run_sweep(5, 0, 1, 1, rand_word(), 1'b0, 1'b0, 2);
        run_sweep(3, 0, 0, 0, rand_word(), 1'b0, 1'b0, -1);

        // Final RAM contents against the model.
        for (int a = 0; a < NW; a++) begin
            host_access(1'b0, AW'(a), '0, rd);
            check($sformatf("readback_%0d", a), rd, exp_mem[a]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
